// File: rtl/pwm_cap_pkg.sv
// Shared types and default sizing for the PWM capture block.
// Optional input glitch filter is enabled by defining PWM_CAPTURE_FILT_EN.
package pwm_cap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_cap_state_t;

    localparam int PWM_CNT_W    = 11;
    localparam int PWM_TO_CYC   = 4095;
    localparam int PWM_FILT_LEN = 3;

endpackage

// File: rtl/pwm_cap_sync.sv
// Input conditioning for pwm_capture: 2-FF synchroniser, optional level filter
// (macro PWM_CAPTURE_FILT_EN) and rise/fall detection on the conditioned level.
module pwm_cap_sync
    import pwm_cap_pkg::*;
`ifdef PWM_CAPTURE_FILT_EN
#(
    parameter int FILT_LEN = PWM_FILT_LEN
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pwm_in;
            sync_q2 <= sync_q1;
        end
    end

`ifdef PWM_CAPTURE_FILT_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic [FW-1:0] filt_cnt;
    logic          filt_lvl;

    // The accepted level flips on the FILT_LEN-th consecutive differing sample;
    // any sample that agrees with the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt_lvl <= 1'b0;
        end else if (sync_q2 == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
            filt_cnt <= '0;
            filt_lvl <= sync_q2;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = sync_q2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= lvl;
        end
    end

    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM high-time / period measurement with stuck-line timeout.
// Optional input glitch filter is enabled by defining PWM_CAPTURE_FILT_EN.
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int CNT_W  = PWM_CNT_W,
    parameter int TO_CYC = PWM_TO_CYC
`ifdef PWM_CAPTURE_FILT_EN
    ,
    parameter int FILT_LEN = PWM_FILT_LEN
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W:0]   high_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic             vld,
    output logic             stuck,
    output logic             stuck_lvl
);

    localparam int W = CNT_W + 1;
    localparam logic [W-1:0] TO_VAL = W'(TO_CYC);
    localparam logic [W-1:0] ONE    = W'(1);

    logic lvl;
    logic rise;
    logic fall;

    pwm_cap_state_t state_q;
    pwm_cap_state_t state_d;

    logic [W-1:0] hcnt_q, hcnt_d;
    logic [W-1:0] pcnt_q, pcnt_d;
    logic [W-1:0] tmr_q, tmr_d;
    logic [W-1:0] high_cnt_d, period_cnt_d;
    logic         vld_d, stuck_d, stuck_lvl_d;
    logic         timeout;

`ifdef PWM_CAPTURE_FILT_EN
    pwm_cap_sync #(.FILT_LEN(FILT_LEN)) u_sync (
`else
    pwm_cap_sync u_sync (
`endif
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .lvl    (lvl),
        .rise   (rise),
        .fall   (fall)
    );

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    // An edge in the same cycle as tmr reaching TO_CYC means the line is alive,
    // so the edge always takes priority over the timeout.
    assign timeout = (tmr_q == TO_VAL) && !rise && !fall;

    // vld is a one-cycle strobe with no backpressure: high_cnt/period_cnt change
    // only in the cycle vld is high and hold their value until the next strobe.
    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        pcnt_d       = pcnt_q;
        high_cnt_d   = high_cnt;
        period_cnt_d = period_cnt;
        vld_d        = 1'b0;
        stuck_d      = stuck;
        stuck_lvl_d  = stuck_lvl;

        if (rise || fall) begin
            tmr_d = '0;
        end else if (tmr_q != TO_VAL) begin
            tmr_d = tmr_q + ONE;
        end else begin
            tmr_d = tmr_q;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = ONE;
                    pcnt_d  = ONE;
                    stuck_d = 1'b0;
                end
            end
            HIGH: begin
                pcnt_d = sat_inc(pcnt_q);
                if (fall) begin
                    state_d = LOW;
                end else begin
                    hcnt_d = sat_inc(hcnt_q);
                end
            end
            LOW: begin
                if (rise) begin
                    high_cnt_d   = hcnt_q;
                    period_cnt_d = pcnt_q;
                    vld_d        = 1'b1;
                    hcnt_d       = ONE;
                    pcnt_d       = ONE;
                    state_d      = HIGH;
                end else begin
                    pcnt_d = sat_inc(pcnt_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout) begin
            state_d     = IDLE;
            stuck_d     = 1'b1;
            stuck_lvl_d = lvl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            pcnt_q     <= '0;
            tmr_q      <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            vld        <= 1'b0;
            stuck      <= 1'b0;
            stuck_lvl  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            pcnt_q     <= pcnt_d;
            tmr_q      <= tmr_d;
            high_cnt   <= high_cnt_d;
            period_cnt <= period_cnt_d;
            vld        <= vld_d;
            stuck      <= stuck_d;
            stuck_lvl  <= stuck_lvl_d;
        end
    end

endmodule
